// File: rtl/gf180mcu_osu_sc_12t_rrarb_if.sv
// Request/grant bundle for the round-robin arbiter macro.
//   req   : requester -> arbiter, one level-sensitive bit per requester
//   gnt   : arbiter -> requester, registered one-hot grant (or all zeros)
//   valid : arbiter -> requester, high when any gnt bit is high
//   owner : arbiter -> requester, binary index of the granted requester (0 when idle)
// master = requester side, slave = arbiter side.
interface gf180mcu_osu_sc_12t_rrarb_if #(
    parameter int N = 4
);
    localparam int OW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          valid;
    logic [OW-1:0] owner;

    modport master (output req, input gnt, input valid, input owner);
    modport slave  (input req, output gnt, output valid, output owner);
endinterface

// File: rtl/gf180mcu_osu_sc_12t_rrarb.sv
// Round-robin arbiter sharing one downstream resource among N requesters.
// The grant is registered and held while the owner keeps requesting; once
// the owner has held for MAX_HOLD consecutive cycles and someone else is
// waiting, the grant moves on so nobody starves.
//
// Ports:
//   CLK : rising-edge clock
//   RN  : asynchronous active-low reset (release is synchronous to CLK)
//   bus : slave side of gf180mcu_osu_sc_12t_rrarb_if (req in; gnt/valid/owner out)
//
// Parameters:
//   N        : number of requesters (2..8)
//   MAX_HOLD : max consecutive owner cycles while others wait (1..255)
//   CW       : hold counter width, 2**CW > MAX_HOLD
module gf180mcu_osu_sc_12t_rrarb #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input logic                          CLK,
    input logic                          RN,
    gf180mcu_osu_sc_12t_rrarb_if.slave   bus
);
    localparam int OW = $clog2(N);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state;
    logic [OW-1:0] ptr;
    logic [CW-1:0] hcnt;
    logic [N-1:0]  gnt_q;
    logic          valid_q;
    logic [OW-1:0] owner_q;

    // (i + 1) mod N without a divider.
    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
        return (i == OW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    logic [N-1:0]  cand;       // requesters eligible for a new grant
    logic [OW-1:0] search_from;
    logic          pick_hit;
    logic [OW-1:0] pick_idx;
    logic          owner_req;
    logic          at_limit;

    // In BUSY the owner is masked out of the candidate set, so pick_hit is
    // exactly "someone else is waiting". Searching from owner+1 covers both
    // release and preempt, since both move the pointer past the owner.
    always_comb begin
        int j;
        cand        = (state == BUSY) ? (bus.req & ~gnt_q) : bus.req;
        search_from = (state == BUSY) ? next_idx(owner_q) : ptr;
        pick_hit    = 1'b0;
        pick_idx    = '0;
        j           = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(search_from) + k) % N;
            if (!pick_hit && cand[j]) begin
                pick_hit = 1'b1;
                pick_idx = OW'(j);
            end
        end
    end

    assign owner_req = |(bus.req & gnt_q);
    assign at_limit  = (hcnt == CW'(MAX_HOLD));

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state   <= IDLE;
            ptr     <= '0;
            hcnt    <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            owner_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_hit) begin
                        state   <= BUSY;
                        gnt_q   <= N'(1) << pick_idx;
                        valid_q <= 1'b1;
                        owner_q <= pick_idx;
                        hcnt    <= CW'(1);
                    end
                end
                BUSY: begin
                    // Release takes priority over preempt when both apply.
                    if (!owner_req || (at_limit && pick_hit)) begin
                        ptr <= next_idx(owner_q);
                        if (pick_hit) begin
                            // Hand over on the same edge: no dead cycle.
                            gnt_q   <= N'(1) << pick_idx;
                            owner_q <= pick_idx;
                            hcnt    <= CW'(1);
                        end else begin
                            state   <= IDLE;
                            gnt_q   <= '0;
                            valid_q <= 1'b0;
                            owner_q <= '0;
                            hcnt    <= '0;
                        end
                    end else if (!at_limit) begin
                        // Saturating hold count; a lone owner keeps the grant forever.
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    owner_q <= '0;
                    hcnt    <= '0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.valid = valid_q;
    assign bus.owner = owner_q;
endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_rrarb.sv
// Directed bench for the round-robin arbiter: reset behaviour, single owner,
// hold-limit rotation, back-to-back handover with pointer wrap, a
// random-toggle run checked against one-hot / wait-bound invariants, and a
// MAX_HOLD=1 instance for strict rotation.
module tb_gf180mcu_osu_sc_12t_rrarb;
    localparam int N     = 4;
    localparam int MH    = 8;
    localparam int BOUND = (N - 1) * MH + 1;

    logic CLK = 1'b0;
    logic RN  = 1'b0;
    always #5 CLK = ~CLK;

    gf180mcu_osu_sc_12t_rrarb_if #(.N(N)) bus  ();
    gf180mcu_osu_sc_12t_rrarb_if #(.N(N)) bus1 ();

    gf180mcu_osu_sc_12t_rrarb #(.N(N), .MAX_HOLD(MH), .CW(8)) dut (
        .CLK (CLK),
        .RN  (RN),
        .bus (bus)
    );

    gf180mcu_osu_sc_12t_rrarb #(.N(N), .MAX_HOLD(1), .CW(8)) dut1 (
        .CLK (CLK),
        .RN  (RN),
        .bus (bus1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_g(input string tag, input logic [3:0] g, input logic [1:0] own,
                            input logic v);
        chk({tag, "_gnt"},   32'(bus.gnt),   32'(g));
        chk({tag, "_owner"}, 32'(bus.owner), 32'(own));
        chk({tag, "_valid"}, 32'(bus.valid), 32'(v));
    endtask

    initial begin
        int wait_cnt [N];
        int maxw;
        logic [3:0] exp_g;
        logic [3:0] flip;

        bus.req  = 4'b1111;
        bus1.req = 4'b0000;
        RN       = 1'b0;

        // Reset held with all requesting: nothing granted.
        repeat (3) tick();
        expect_g("rst", 4'b0000, 2'd0, 1'b0);
        RN = 1'b1;
        #2;
        expect_g("rel_pre_edge", 4'b0000, 2'd0, 1'b0);
        tick();
        expect_g("rel_first", 4'b0001, 2'd0, 1'b1);

        // Asynchronous clear mid-grant.
        #2 RN = 1'b0;
        #1;
        expect_g("async_rst", 4'b0000, 2'd0, 1'b0);
        RN      = 1'b1;
        bus.req = 4'b0000;
        tick();
        expect_g("idle", 4'b0000, 2'd0, 1'b0);

        // Single requester holds without preemption.
        bus.req = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            tick();
            expect_g("single", 4'b0100, 2'd2, 1'b1);
        end
        bus.req = 4'b0000;
        tick();
        expect_g("single_drop", 4'b0000, 2'd0, 1'b0);

        // Hold limit: pointer is at 3, search wraps to 0 first.
        bus.req = 4'b0011;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (((k / MH) % 2) == 0) expect_g("starve", 4'b0001, 2'd0, 1'b1);
            else                     expect_g("starve", 4'b0010, 2'd1, 1'b1);
        end
        bus.req = 4'b0000;
        tick();
        expect_g("starve_drop", 4'b0000, 2'd0, 1'b0);

        // Back-to-back handover and pointer wrap.
        bus.req = 4'b0001;
        tick();
        expect_g("b2b_own0", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b1001;
        tick();
        expect_g("b2b_hold", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b1000;
        tick();
        expect_g("b2b_hand", 4'b1000, 2'd3, 1'b1);
        bus.req = 4'b0111;
        tick();
        expect_g("wrap_to0", 4'b0001, 2'd0, 1'b1);
        bus.req = 4'b0110;
        tick();
        expect_g("wrap_to1", 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b0000;
        tick();
        expect_g("wrap_drop", 4'b0000, 2'd0, 1'b0);

        // Random toggling: invariants and starvation bound.
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 7) == 0);
            bus.req = bus.req ^ flip;
            tick();
            chk("rnd_onehot", 32'($onehot0(bus.gnt)), 32'd1);
            chk("rnd_gnt_req", 32'(bus.gnt & ~bus.req), 32'd0);
            chk("rnd_valid", 32'(bus.valid), 32'(|bus.gnt));
            maxw = 0;
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && !bus.gnt[i]) wait_cnt[i]++;
                else                           wait_cnt[i] = 0;
                if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
            end
            chk("rnd_wait_bound", 32'(maxw <= BOUND), 32'd1);
        end

        // MAX_HOLD=1: strict rotation.
        bus.req  = 4'b0000;
        RN       = 1'b0;
        bus1.req = 4'b1111;
        #1;
        RN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_g = 4'b0001 << (k % 4);
            chk("mh1_gnt",   32'(bus1.gnt),   32'(exp_g));
            chk("mh1_owner", 32'(bus1.owner), 32'(k % 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
